// File: rtl/dense_argmax_seq.sv
// Time-multiplexed fully-connected classifier layer: one activation per beat is
// multiplied against N_OUT weights, then bias/shift/saturating ReLU and argmax.
module dense_argmax_seq #(
    parameter int N_IN  = 144,
    parameter int N_OUT = 4,
    parameter int DW    = 35,
    parameter int WW    = 35,
    parameter int AW    = DW + WW + $clog2(N_IN) + 1,
    parameter int SHIFT = 0,
    parameter int OW    = 17,
    localparam int CW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int IW   = $clog2(N_OUT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic                  abort,
    output logic [CW-1:0]         w_addr,
    input  logic [N_OUT*WW-1:0]   w_data,
    input  logic [N_OUT*AW-1:0]   bias,
    output logic                  out_valid,
    output logic [N_OUT*OW-1:0]   out_act,
    output logic [IW-1:0]         max_index,
    output logic                  max_changed
);

    localparam int PW = DW + WW;
    localparam logic [AW:0] SAT_MAX = (AW+1)'((64'd1 << (OW - 1)) - 64'd1);

    typedef enum logic [1:0] {ST_ACCUM, ST_FINISH, ST_PUBLISH} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [N_OUT-1:0][AW-1:0]      acc_q, acc_d;
    logic [N_OUT*OW-1:0]           out_act_q, out_act_d;
    logic [IW-1:0]                 max_index_q, max_index_d;
    logic                          out_valid_q, out_valid_d;
    logic                          max_changed_q, max_changed_d;

    logic                          accept;
    logic                          last_beat;
    logic signed [PW-1:0]          prod;
    logic signed [AW:0]            sum_full;
    logic signed [AW:0]            shifted;
    logic [OW-1:0]                 best;
    logic [IW-1:0]                 best_idx;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready is low outside ACCUM, while reset is asserted, and during abort.
    assign in_ready  = (state_q == ST_ACCUM) && !reset && !abort;
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CW'(N_IN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:   if (accept && last_beat) state_d = ST_FINISH;
            ST_FINISH:  state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_ACCUM;
            default:    state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        out_act_d     = out_act_q;
        max_index_d   = max_index_q;
        out_valid_d   = 1'b0;
        max_changed_d = 1'b0;
        prod          = '0;
        sum_full      = '0;
        shifted       = '0;
        best          = '0;
        best_idx      = '0;
        case (state_q)
            ST_ACCUM: begin
                if (abort) begin
                    cnt_d = '0;
                    acc_d = '0;
                end else if (accept) begin
                    for (int n = 0; n < N_OUT; n++) begin
                        prod     = PW'($signed(in_data)) * PW'($signed(w_data[n*WW +: WW]));
                        acc_d[n] = acc_q[n] + {{(AW-PW){prod[PW-1]}}, prod};
                    end
                    cnt_d = last_beat ? '0 : cnt_q + CW'(1);
                end
            end
            ST_FINISH: begin
                // Bias add is one bit wider than the accumulator so it cannot wrap.
                for (int n = 0; n < N_OUT; n++) begin
                    sum_full = $signed({acc_q[n][AW-1], acc_q[n]})
                             + $signed({bias[n*AW+AW-1], bias[n*AW +: AW]});
                    shifted  = sum_full >>> SHIFT;
                    if (shifted[AW])
                        out_act_d[n*OW +: OW] = '0;
                    else if ($unsigned(shifted) > SAT_MAX)
                        out_act_d[n*OW +: OW] = SAT_MAX[OW-1:0];
                    else
                        out_act_d[n*OW +: OW] = shifted[OW-1:0];
                end
            end
            ST_PUBLISH: begin
                // Strict greater-than keeps the lowest index on ties.
                best = out_act_q[OW-1:0];
                for (int n = 1; n < N_OUT; n++) begin
                    if (out_act_q[n*OW +: OW] > best) begin
                        best     = out_act_q[n*OW +: OW];
                        best_idx = IW'(n);
                    end
                end
                max_index_d   = best_idx;
                max_changed_d = (best_idx != max_index_q);
                out_valid_d   = 1'b1;
                acc_d         = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            out_act_q     <= '0;
            max_index_q   <= '0;
            out_valid_q   <= 1'b0;
            max_changed_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            out_act_q     <= out_act_d;
            max_index_q   <= max_index_d;
            out_valid_q   <= out_valid_d;
            max_changed_q <= max_changed_d;
        end
    end

    assign w_addr      = cnt_q;
    assign out_act     = out_act_q;
    assign max_index   = max_index_q;
    assign out_valid   = out_valid_q;
    assign max_changed = max_changed_q;

endmodule

// File: tb/tb_dense_argmax_seq.sv
// Directed bench for dense_argmax_seq: table of identity-weight frames plus
// hand-written sequences for weights, abort and mid-frame reset.
module tb_dense_argmax_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int DW    = 35;
    localparam int WW    = 35;
    localparam int AW    = DW + WW + $clog2(N_IN) + 1;
    localparam int OW    = 17;
    localparam int CW    = 2;
    localparam int IW    = 2;
    localparam longint SAT = 65535;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 abort;
    logic [DW-1:0]        in_data;
    logic [N_OUT*WW-1:0]  w_data;
    logic [N_OUT*AW-1:0]  bias;

    logic                 in_ready, s_in_ready;
    logic [CW-1:0]        w_addr, s_w_addr;
    logic                 out_valid, s_out_valid;
    logic [N_OUT*OW-1:0]  out_act, s_out_act;
    logic [IW-1:0]        max_index, s_max_index;
    logic                 max_changed, s_max_changed;

    dense_argmax_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .SHIFT(0), .OW(OW)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .abort(abort), .w_addr(w_addr), .w_data(w_data),
        .bias(bias), .out_valid(out_valid), .out_act(out_act),
        .max_index(max_index), .max_changed(max_changed)
    );

    dense_argmax_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .SHIFT(2), .OW(OW)) u_shift (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .abort(abort), .w_addr(s_w_addr), .w_data(w_data),
        .bias(bias), .out_valid(s_out_valid), .out_act(s_out_act),
        .max_index(s_max_index), .max_changed(s_max_changed)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Weight store: combinational, same-cycle read at w_addr
    logic signed [WW-1:0] w_mem [N_IN][N_OUT];
    always_comb begin
        w_data = '0;
        for (int n = 0; n < N_OUT; n++) w_data[n*WW +: WW] = w_mem[w_addr][n];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        longint x  [N_IN];
        longint b  [N_OUT];
        longint e  [N_OUT];
        longint es [N_OUT];
        int     idx;
        int     chg;
        bit     gaps;
    } vec_t;

    vec_t vecs [9];
    int   nv = 0;

    function automatic vec_t mk(input longint x0, x1, x2, x3,
                                input longint e0, e1, e2, e3,
                                input longint s0, s1, s2, s3,
                                input int idx, input int chg, input bit gaps);
        vec_t v;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        for (int n = 0; n < N_OUT; n++) v.b[n] = 0;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        v.es[0] = s0; v.es[1] = s1; v.es[2] = s2; v.es[3] = s3;
        v.idx = idx; v.chg = chg; v.gaps = gaps;
        return v;
    endfunction

    task automatic set_identity();
        for (int i = 0; i < N_IN; i++)
            for (int n = 0; n < N_OUT; n++)
                w_mem[i][n] = (i == n) ? WW'(1) : WW'(0);
    endtask

    task automatic set_bias(input vec_t v);
        longint b;
        for (int n = 0; n < N_OUT; n++) begin
            b = v.b[n];
            bias[n*AW +: AW] = {{(AW-64){b[63]}}, b};
        end
    endtask

    task automatic check_acts(input string tag);
        chk({tag, " act0"}, longint'(out_act[0*OW +: OW]), 0);
        chk({tag, " act1"}, longint'(out_act[1*OW +: OW]), 0);
        chk({tag, " act2"}, longint'(out_act[2*OW +: OW]), 0);
        chk({tag, " act3"}, longint'(out_act[3*OW +: OW]), 0);
    endtask

    // Driver + checker for one frame; called at a negedge with the DUT in ACCUM.
    task automatic run_and_check(input vec_t v, input string tag);
        longint xv;
        set_bias(v);
        for (int b = 0; b < N_IN; b++) begin
            if (v.gaps) begin
                for (int g = 0; g < 1 + int'($urandom_range(0, 1)); g++) begin
                    in_valid = 1'b0;
                    in_data  = DW'($urandom_range(0, 255));
                    #1 chk($sformatf("%s idle w_addr b%0d", tag, b), longint'(w_addr), b);
                    @(negedge clk);
                end
            end
            xv       = v.x[b];
            in_valid = 1'b1;
            in_data  = xv[DW-1:0];
            #1;
            chk($sformatf("%s w_addr b%0d", tag, b), longint'(w_addr), b);
            chk($sformatf("%s s_w_addr b%0d", tag, b), longint'(s_w_addr), b);
            chk($sformatf("%s in_ready b%0d", tag, b), longint'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk({tag, " finish out_valid"}, longint'(out_valid), 0);
        chk({tag, " finish in_ready"}, longint'(in_ready), 0);
        @(negedge clk);
        chk({tag, " publish out_valid"}, longint'(out_valid), 0);
        chk({tag, " publish in_ready"}, longint'(in_ready), 0);
        for (int n = 0; n < N_OUT; n++)
            chk($sformatf("%s act%0d", tag, n), longint'(out_act[n*OW +: OW]), v.e[n]);
        @(negedge clk);
        chk({tag, " out_valid"}, longint'(out_valid), 1);
        chk({tag, " s_out_valid"}, longint'(s_out_valid), 1);
        chk({tag, " in_ready back"}, longint'(in_ready), 1);
        chk({tag, " max_index"}, longint'(max_index), v.idx);
        chk({tag, " max_changed"}, longint'(max_changed), v.chg);
        for (int n = 0; n < N_OUT; n++)
            chk($sformatf("%s shift act%0d", tag, n), longint'(s_out_act[n*OW +: OW]), v.es[n]);
        @(negedge clk);
        chk({tag, " pulse end out_valid"}, longint'(out_valid), 0);
        chk({tag, " pulse end max_changed"}, longint'(max_changed), 0);
        chk({tag, " hold max_index"}, longint'(max_index), v.idx);
    endtask

    task automatic send_beats(input longint x0, input longint x1);
        in_valid = 1'b1; in_data = x0[DW-1:0]; @(negedge clk);
        in_valid = 1'b1; in_data = x1[DW-1:0]; @(negedge clk);
        in_valid = 1'b0; in_data = '0;
    endtask

    vec_t v;

    initial begin
        reset = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = '0; bias = '0;
        set_identity();

        vecs[0] = mk(3, 7, 2, 5,      3, 7, 2, 5,   0, 1, 0, 1,  1, 1, 0);
        vecs[1] = mk(3, 7, 2, 5,      3, 7, 2, 5,   0, 1, 0, 1,  1, 0, 0);
        vecs[2] = mk(1, 1, 9, 1,      1, 1, 9, 1,   0, 0, 2, 0,  2, 1, 0);
        vecs[3] = mk(4, 4, 4, 4,      4, 4, 4, 4,   1, 1, 1, 1,  0, 1, 0);
        vecs[4] = mk(-1, -5, -3, -7,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
        vecs[5] = mk(0, 7, 3, 1,      SAT, 0, 13, 1, SAT, 0, 3, 0, 0, 0, 0);
        vecs[5].b[0] = 64'sd1 << 20; vecs[5].b[1] = -100; vecs[5].b[2] = 10;
        vecs[6] = mk(3, 7, 2, 5,      3, 7, 2, 5,   0, 1, 0, 1,  1, 1, 1);
        vecs[7] = mk(2, 9, 9, 1,      2, 9, 9, 1,   0, 2, 2, 0,  1, 0, 0);
        vecs[8] = mk(5, 1, 8, 8,      5, 1, 8, 8,   1, 0, 2, 2,  2, 1, 0);
        nv = 9;

        repeat (2) @(negedge clk);
        #1;
        chk("reset in_ready", longint'(in_ready), 0);
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset max_index", longint'(max_index), 0);
        chk("reset max_changed", longint'(max_changed), 0);
        chk("reset w_addr", longint'(w_addr), 0);
        check_acts("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < nv; i++) run_and_check(vecs[i], $sformatf("vec%0d", i));

        // Non-identity weights, one negative column
        for (int i = 0; i < N_IN; i++) begin
            w_mem[i][0] = 1; w_mem[i][1] = 2; w_mem[i][2] = 3; w_mem[i][3] = -2;
        end
        run_and_check(mk(1, 2, 3, -1,  5, 10, 15, 0,  1, 2, 3, 0,  2, 0, 0), "mixed");

        // Wide products: 2^20 * 2^20 must not be truncated; bias cancels -2^40
        for (int i = 0; i < N_IN; i++)
            for (int n = 0; n < N_OUT; n++) w_mem[i][n] = 7;
        w_mem[0][0] = 1 <<< 20; w_mem[0][1] = -(1 <<< 20); w_mem[0][2] = 0; w_mem[0][3] = 1;
        v = mk(64'sd1 << 20, 0, 0, 0,  SAT, 5, 0, SAT,  SAT, 1, 0, SAT,  0, 1, 0);
        v.b[1] = (64'sd1 << 40) + 5;
        run_and_check(v, "wide");
        set_identity();

        // Abort after two beats discards the partial frame
        send_beats(9, 9);
        abort = 1'b1; in_valid = 1'b1; in_data = DW'(9);
        #1 chk("abort in_ready", longint'(in_ready), 0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort w_addr", longint'(w_addr), 0);
        chk("abort out_valid", longint'(out_valid), 0);
        chk("abort hold max_index", longint'(max_index), 0);
        @(negedge clk);
        run_and_check(mk(3, 7, 2, 5,  3, 7, 2, 5,  0, 1, 0, 1,  1, 1, 0), "post_abort");

        // Asynchronous reset in the middle of a frame
        send_beats(8, 8);
        #2 reset = 1'b1;
        #1;
        chk("midreset in_ready", longint'(in_ready), 0);
        chk("midreset out_valid", longint'(out_valid), 0);
        chk("midreset max_index", longint'(max_index), 0);
        chk("midreset w_addr", longint'(w_addr), 0);
        check_acts("midreset");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midreset quiet c%0d", c), longint'(out_valid), 0);
        end
        run_and_check(mk(4, 4, 4, 4,  4, 4, 4, 4,  1, 1, 1, 1,  0, 0, 0), "post_reset_tie");
        run_and_check(mk(1, 1, 9, 1,  1, 1, 9, 1,  0, 0, 2, 0,  2, 1, 0), "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dense_argmax_seq.md
# dense_argmax_seq

Time-multiplexed fully-connected classifier layer: accepts one input activation per accepted beat, multiply-accumulates it against N_OUT weights read from an external weight store, then adds bias, rescales, applies saturating ReLU, and publishes all activations plus the argmax class index. It replaces fully parallel multiplier and adder-tree layers where area matters, and sits after the feature-extraction stages, driving the class-index consumer.

## Interface
- N_IN, 144, input activations per frame (≥1)
- N_OUT, 4, output neurons / classes (≥2)
- DW, 35, input activation width, signed
- WW, 35, weight width, signed
- AW, DW+WW+$clog2(N_IN)+1, accumulator and bias width, signed
- SHIFT, 0, arithmetic right shift applied after bias add
- OW, 17, output activation width, signed (always non-negative after ReLU)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- in_data  in  DW  signed activation, element w_addr of current frame
- abort  in  1  synchronous; drop the partial frame
- w_addr  out  $clog2(N_IN) (min 1)  current element index
- w_data  in  N_OUT*WW  weights for element w_addr; neuron n at bits [n*WW +: WW]; combinational, same-cycle
- bias  in  N_OUT*AW  per-neuron bias, same packing; static during a frame
- out_valid  out  1  one-cycle pulse: results updated
- out_act  out  N_OUT*OW  registered activations, neuron n at [n*OW +: OW]
- max_index  out  $clog2(N_OUT)  registered argmax
- max_changed  out  1  one-cycle pulse coincident with out_valid when max_index changed

## Operation
- States: ACCUM, FINISH, PUBLISH. Reset state ACCUM, cnt=0, all acc=0.
- ACCUM: in_ready=1 (0 while reset asserted). w_addr=cnt. On accept (in_valid&&in_ready): acc[n] += sext(in_data*w_data[n]); cnt++. If accepting with cnt==N_IN-1: cnt←0, go FINISH. in_valid low: hold everything.
- FINISH: in_ready=0. For each n: s=(acc[n]+bias[n])>>>SHIFT; act = s<0 ? 0 : (s>2^(OW-1)-1 ? 2^(OW-1)-1 : s); register into out_act. Go PUBLISH.
- PUBLISH: in_ready=0. Register max_index = lowest n with maximal out_act (strict-greater scan from n=0; ties to lower index, all-zero → 0). out_valid=1, max_changed=(new index != previous published index). Clear all acc. Go ACCUM.
- Products full precision DW+WW, sign-extended to AW; AW sizing guarantees no accumulator overflow. Bias sign-extended arithmetic in AW+1 bits before shift.
- abort in ACCUM: acc←0, cnt←0, no accept that cycle (in_ready forced 0), outputs unchanged. abort in FINISH/PUBLISH ignored.
- out_act, max_index hold between frames.

## Timing
- Reset values: in_ready 0 during reset, out_valid 0, max_changed 0, out_act 0, max_index 0, w_addr 0; previous-index reference 0.
- Last beat accepted at edge k → out_act valid after edge k+1 → out_valid, max_index, max_changed high for the cycle after edge k+2; in_ready returns high that same cycle.
- Throughput: N_IN+2 cycles per frame with continuous in_valid.
- w_data must be valid in the same cycle as w_addr; no read latency.
- Reset mid-frame: partial frame discarded, no out_valid.

## Test plan
- N_IN=4, N_OUT=4, SHIFT=0, zero bias, weights identity-like (w[i][n]=1 if i==n), inputs 3,7,2,5 continuous → out_valid exactly 2 cycles after last accept; out_act=(3,7,2,5), max_index=1, max_changed=1.
- Same frame repeated → max_index=1, max_changed=0; then inputs 1,1,9,1 → max_index=2, max_changed=1.
- Ties: inputs 4,4,4,4 → max_index=0; all negative inputs → out_act all 0, max_index=0.
- Saturation/bias: bias[0]=2^20, OW=17 → out_act[0]=65535; bias[1]=-100 with input 7 → out_act[1]=0; SHIFT=2, sum 13 → 3.
- in_valid toggling randomly every other cycle → identical results to continuous case; w_addr advances only on accepts.
- abort after 2 beats, then full frame 3,7,2,5 → results equal to clean frame; async reset mid-frame → all outputs 0, no out_valid, next full frame correct.
